// File: rtl/fsm_count_pkg.sv
// Shared encodings for the multi-channel w/z count detector.
package fsm_count_pkg;

    // Per-channel FSM state; 2'b00 is unused and decodes back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_ACCUM  = 2'b10,
        ST_DETECT = 2'b11
    } state_e;

    // Global counting mode.
    localparam logic MODE_CUMUL  = 1'b0;
    localparam logic MODE_CONSEC = 1'b1;

endpackage : fsm_count_pkg

// File: rtl/fsm_count_chan.sv
// One detector channel: counts w=1 samples and holds z while the threshold is met.
module fsm_count_chan
    import fsm_count_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             w_i,
    output logic             z_o,
    output logic             z_rise_o,
    output logic [CNT_W-1:0] count_o
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               z_rise_q, z_rise_d;
    logic [CNT_W:0]     count_inc;

    // One extra bit so the >= threshold compare cannot wrap.
    assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);

    // Next-state, next-count and entry-pulse logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        z_rise_d = 1'b0;
        if (en_i) begin
            if (thr_i == '0) begin
                state_d = ST_IDLE;
                count_d = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (w_i) begin
                            count_d = CNT_W'(1);
                            state_d = (thr_i == CNT_W'(1)) ? ST_DETECT : ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        if (w_i) begin
                            if (count_inc >= {1'b0, thr_i}) begin
                                state_d = ST_DETECT;
                                count_d = thr_i;
                            end else begin
                                count_d = count_inc[CNT_W-1:0];
                            end
                        end else if (mode_i == MODE_CONSEC) begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end
                    end
                    ST_DETECT: begin
                        if (w_i) begin
                            // Threshold may have been raised; climb toward it, never past.
                            count_d = (count_q < thr_i) ? count_inc[CNT_W-1:0] : thr_i;
                        end else begin
                            state_d = ST_IDLE;
                            count_d = '0;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                endcase
            end
            z_rise_d = (state_d == ST_DETECT) && (state_q != ST_DETECT);
        end
    end

    // State, count and pulse registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            z_rise_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            z_rise_q <= z_rise_d;
        end
    end

    assign z_o      = (state_q == ST_DETECT);
    assign z_rise_o = z_rise_q;
    assign count_o  = count_q;

endmodule : fsm_count_chan

// File: rtl/fsm_count_detect.sv
// Multi-channel count detector: CHANNELS independent fsm_count_chan instances.
module fsm_count_detect
    import fsm_count_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      En,
    input  logic                      Mode,
    input  logic [CHANNELS*CNT_W-1:0] Thresh,
    input  logic [CHANNELS-1:0]       w,
    output logic [CHANNELS-1:0]       z,
    output logic [CHANNELS-1:0]       z_rise,
    output logic [CHANNELS*CNT_W-1:0] Count
);

    // One channel per w bit; Mode, En and Reset are shared.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        fsm_count_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i    (Clk),
            .reset_i  (Reset),
            .en_i     (En),
            .mode_i   (Mode),
            .thr_i    (Thresh[i*CNT_W +: CNT_W]),
            .w_i      (w[i]),
            .z_o      (z[i]),
            .z_rise_o (z_rise[i]),
            .count_o  (Count[i*CNT_W +: CNT_W])
        );
    end

endmodule : fsm_count_detect

// File: tb/tb_fsm_count_detect.sv
// Self-checking bench for fsm_count_detect: directed scenarios plus random traffic vs. a count model.
`timescale 1ns/1ps
module tb_fsm_count_detect;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 4;

    logic            Clk;
    logic            Reset;
    logic            En;
    logic            Mode;
    logic [CH*CW-1:0] Thresh;
    logic [CH-1:0]   w;
    logic [CH-1:0]   z;
    logic [CH-1:0]   z_rise;
    logic [CH*CW-1:0] Count;

    int n_vec;
    int n_err;

    // Reference model: a count per channel plus a "detecting" flag.
    int m_cnt  [CH];
    bit m_det  [CH];
    bit m_rise [CH];

    fsm_count_detect #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .En     (En),
        .Mode   (Mode),
        .Thresh (Thresh),
        .w      (w),
        .z      (z),
        .z_rise (z_rise),
        .Count  (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the rules to the inputs sampled at this edge.
    task automatic model_update();
        for (int i = 0; i < CH; i++) begin
            int thr;
            int nc;
            bit nd;
            thr = int'(Thresh[i*CW +: CW]);
            m_rise[i] = 1'b0;
            if (Reset) begin
                m_cnt[i] = 0;
                m_det[i] = 1'b0;
            end else if (En) begin
                if (thr == 0) begin
                    m_cnt[i] = 0;
                    m_det[i] = 1'b0;
                end else if (w[i]) begin
                    nc = m_cnt[i] + 1;
                    nd = m_det[i] || (nc >= thr);
                    m_rise[i] = nd && !m_det[i];
                    m_cnt[i] = (nc < thr) ? nc : thr;
                    m_det[i] = nd;
                end else if (m_det[i] || Mode) begin
                    m_cnt[i] = 0;
                    m_det[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("z[%0d]", i), 32'(z[i]), 32'(m_det[i]));
            check_eq($sformatf("z_rise[%0d]", i), 32'(z_rise[i]), 32'(m_rise[i]));
            check_eq($sformatf("count[%0d]", i), 32'(Count[i*CW +: CW]), 32'(m_cnt[i]));
        end
    endtask

    // Drive one cycle of inputs on the falling edge, check after the rising edge.
    task automatic step(input logic r, input logic e, input logic m,
                        input logic [CH*CW-1:0] t, input logic [CH-1:0] wv);
        @(negedge Clk);
        Reset  = r;
        En     = e;
        Mode   = m;
        Thresh = t;
        w      = wv;
        @(posedge Clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        logic [5:0] pat;
        n_vec  = 0;
        n_err  = 0;
        Reset  = 1'b1;
        En     = 1'b1;
        Mode   = 1'b0;
        Thresh = '0;
        w      = '0;
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = 0;
            m_det[i]  = 1'b0;
            m_rise[i] = 1'b0;
        end

        // Reset held with w all ones.
        step(1'b1, 1'b1, 1'b0, 16'h1111, 4'hF);
        step(1'b1, 1'b1, 1'b0, 16'h1111, 4'hF);
        check_eq("reset_z", 32'(z), 32'h0);
        check_eq("reset_count", 32'(Count), 32'h0);

        // Cumulative, thr=3: w=1,0,0,1,0,1.
        pat = 6'b101001;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h3333, {CH{pat[k]}});
            if (k == 4) check_eq("cumul_z_before", 32'(z), 32'h0);
        end
        check_eq("cumul_z", 32'(z), 32'hF);
        check_eq("cumul_rise", 32'(z_rise), 32'hF);
        check_eq("cumul_count0", 32'(Count[3:0]), 32'd3);
        step(1'b0, 1'b1, 1'b0, 16'h3333, 4'hF);
        check_eq("cumul_rise_once", 32'(z_rise), 32'h0);

        // Consecutive, thr=3: w=1,1,0,1,1,1.
        step(1'b1, 1'b1, 1'b1, 16'h3333, 4'h0);
        pat = 6'b111011;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b1, 16'h3333, {CH{pat[k]}});
            if (k == 2) check_eq("consec_clear", 32'(Count[3:0]), 32'd0);
        end
        check_eq("consec_z", 32'(z), 32'hF);

        // thr=15 on ch0, thr=0 on the rest, w held high.
        step(1'b1, 1'b1, 1'b0, 16'h000F, 4'h0);
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h000F, 4'hF);
            if (k == 14) check_eq("thr15_z_early", 32'(z[0]), 32'h0);
            if (k == 15) check_eq("thr15_z", 32'(z[0]), 32'h1);
        end
        check_eq("thr15_count", 32'(Count[3:0]), 32'd15);
        check_eq("thr0_z", 32'(z[3:1]), 32'h0);

        // En=0 freeze in ACCUM, lowered threshold, reset out of DETECT.
        step(1'b1, 1'b1, 1'b0, 16'h0005, 4'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0005, 4'h1);
        step(1'b0, 1'b1, 1'b0, 16'h0005, 4'h1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 16'h0005, 4'($urandom));
        check_eq("en0_count", 32'(Count[3:0]), 32'd2);
        check_eq("en0_z", 32'(z[0]), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0005, 4'h1);
        step(1'b0, 1'b1, 1'b0, 16'h0002, 4'h0);
        check_eq("lower_hold", 32'(z[0]), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0002, 4'h1);
        check_eq("lower_detect", 32'(z[0]), 32'h1);
        step(1'b1, 1'b1, 1'b0, 16'h0002, 4'h1);
        check_eq("reset_in_detect", 32'(z[0]), 32'h0);

        // Thresholds 1..4, all w high, then drop w[2].
        step(1'b1, 1'b1, 1'b0, 16'h4321, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h4321, 4'hF);
            check_eq($sformatf("multi_z_edge%0d", k), 32'(z), 32'((1 << k) - 1));
        end
        step(1'b0, 1'b1, 1'b0, 16'h4321, 4'b1011);
        check_eq("multi_drop2", 32'(z), 32'hB);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [CH*CW-1:0] t;
            t = Thresh;
            if ($urandom_range(0, 15) == 0) t = 16'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 31) == 0) ? ~Mode : Mode, t,
                 4'($urandom) | 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fsm_count_detect
